// File: rtl/rs_pkg.sv
// rs_pkg: GF(2^10) arithmetic, generator polynomials and encoder types
// shared by the dual-mode RS(544,514)/RS(528,514) encoder.
package rs_pkg;
    localparam int GF_M = 10;
    localparam logic [GF_M:0] GF_POLY = 11'h409;
    localparam int NPAR_KP4 = 30;
    localparam int NPAR_KR4 = 14;
    localparam logic MODE_KP4 = 1'b0;
    localparam logic MODE_KR4 = 1'b1;

    typedef logic [GF_M-1:0] sym_t;
    typedef logic [0:NPAR_KP4-1][GF_M-1:0] gvec_t;
    typedef enum logic [1:0] {IDLE, DATA, PARITY} enc_state_t;

    function automatic sym_t gf_mul(sym_t a, sym_t b);
        sym_t r = '0;
        for (int i = GF_M - 1; i >= 0; i--) begin
            r = {r[GF_M-2:0], 1'b0} ^ (r[GF_M-1] ? GF_POLY[GF_M-1:0] : '0);
            if (b[i]) r = r ^ a;
        end
        return r;
    endfunction

    // Expands prod_{k<n}(x - alpha^k); the monic x^n term is implicit.
    function automatic gvec_t gen_g(int n);
        sym_t p [0:NPAR_KP4];
        sym_t a = 10'h001;
        gvec_t g;
        for (int j = 0; j <= NPAR_KP4; j++) p[j] = (j == 0) ? 10'h001 : '0;
        for (int k = 0; k < n; k++) begin
            for (int j = k + 1; j > 0; j--) p[j] = p[j-1] ^ gf_mul(p[j], a);
            p[0] = gf_mul(p[0], a);
            a = gf_mul(a, 10'h002);
        end
        for (int j = 0; j < NPAR_KP4; j++) g[j] = (j < n) ? p[j] : '0;
        return g;
    endfunction

    localparam gvec_t G_KP4 = gen_g(NPAR_KP4);
    localparam gvec_t G_KR4 = gen_g(NPAR_KR4);
endpackage

// File: rtl/gf1024_mul.sv
// gf1024_mul: combinational GF(2^10) symbol multiplier.
module gf1024_mul
    import rs_pkg::*;
(
    input  sym_t a,
    input  sym_t b,
    output sym_t p
);
    assign p = gf_mul(a, b);
endmodule

// File: rtl/rs_enc_dual.sv
// rs_enc_dual: systematic RS encoder over GF(2^10), KP4 (30 parity) or
// KR4 (14 parity) chosen per codeword at SOP; registered outputs.
module rs_enc_dual
    import rs_pkg::*;
#(
    parameter int SYM_W    = 10,
    parameter int K        = 514,
    parameter int NPAR_MAX = 30
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             mode,
    input  logic             sop,
    input  logic             valid_in,
    input  logic [SYM_W-1:0] data_in,
    output logic             ready,
    output logic             valid_out,
    output logic [SYM_W-1:0] data_out,
    output logic             sop_out,
    output logic             eop_out,
    output logic             err_abort
);
    enc_state_t state, state_n;
    logic mode_q, eff_mode, acc, sop_acc, upd;
    logic valid_n, sop_n, eop_n, err_n;
    logic [9:0] cnt, cnt_n;
    logic [4:0] pcnt, pcnt_n, top;
    sym_t fb, data_n;
    sym_t r [NPAR_MAX];
    sym_t r_n [NPAR_MAX];
    sym_t base [NPAR_MAX];
    sym_t prod [NPAR_MAX];

    assign acc      = valid_in && ready;
    assign sop_acc  = acc && sop;
    assign eff_mode = sop_acc ? mode : mode_q;
    assign top      = (eff_mode == MODE_KR4) ? 5'(NPAR_KR4 - 1) : 5'(NPAR_KP4 - 1);

    // An SOP restarts the LFSR from zero in the same cycle it is processed.
    always_comb begin
        for (int i = 0; i < NPAR_MAX; i++) base[i] = sop_acc ? '0 : r[i];
        fb  = data_in ^ base[top];
        upd = acc && (sop || state == DATA);
    end

    for (genvar i = 0; i < NPAR_MAX; i++) begin : g_tap
        if (i < NPAR_KP4) begin : g_mul
            gf1024_mul u_mul (
                .a(fb),
                .b((eff_mode == MODE_KR4) ? G_KR4[i] : G_KP4[i]),
                .p(prod[i])
            );
        end else begin : g_zero
            assign prod[i] = '0;
        end
    end

    // Taps above the active parity depth stay zero so a mode switch starts clean.
    always_comb begin
        r_n[0] = (state == PARITY) ? '0 : upd ? prod[0] : r[0];
        for (int i = 1; i < NPAR_MAX; i++)
            r_n[i] = (i > int'(top)) ? '0 : (state == PARITY) ? r[i-1] : upd ? base[i-1] ^ prod[i] : r[i];
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        pcnt_n  = pcnt;
        valid_n = 1'b0;
        data_n  = '0;
        sop_n   = 1'b0;
        eop_n   = 1'b0;
        err_n   = 1'b0;
        if (sop_acc) begin
            cnt_n   = 10'd1;
            state_n = DATA;
            valid_n = 1'b1;
            data_n  = data_in;
            sop_n   = 1'b1;
            err_n   = (state == DATA);
        end else if (acc && state == DATA) begin
            cnt_n   = cnt + 10'd1;
            state_n = (cnt_n == 10'(K)) ? PARITY : DATA;
            valid_n = 1'b1;
            data_n  = data_in;
        end else if (acc) begin
            err_n = 1'b1;
        end else if (state == PARITY) begin
            valid_n = 1'b1;
            data_n  = r[top];
            eop_n   = (pcnt == top);
            pcnt_n  = eop_n ? '0 : pcnt + 5'd1;
            state_n = eop_n ? IDLE : PARITY;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            mode_q    <= MODE_KP4;
            cnt       <= '0;
            pcnt      <= '0;
            r         <= '{default: '0};
            ready     <= 1'b0;
            valid_out <= 1'b0;
            data_out  <= '0;
            sop_out   <= 1'b0;
            eop_out   <= 1'b0;
            err_abort <= 1'b0;
        end else begin
            state     <= state_n;
            mode_q    <= eff_mode;
            cnt       <= cnt_n;
            pcnt      <= pcnt_n;
            r         <= r_n;
            ready     <= (state_n != PARITY);
            valid_out <= valid_n;
            data_out  <= data_n;
            sop_out   <= sop_n;
            eop_out   <= eop_n;
            err_abort <= err_n;
        end
    end
endmodule

// File: tb/tb_rs_enc_dual.sv
// tb_rs_enc_dual: scoreboard bench for rs_enc_dual; expected codewords come
// from a table-based GF model doing polynomial long division.
module tb_rs_enc_dual;
    localparam int K = 514;

    typedef struct packed {
        logic [9:0] d;
        logic       s;
        logic       e;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic mode = 1'b0;
    logic sop = 1'b0;
    logic valid_in = 1'b0;
    logic [9:0] data_in = '0;
    logic ready, valid_out, sop_out, eop_out, err_abort;
    logic [9:0] data_out;

    int checks = 0;
    int errors = 0;
    int err_pulses = 0;
    int b2b_left = 0;
    bit eop_seen = 1'b0;
    exp_t sb[$];
    exp_t cur;
    logic [9:0] gexp [0:1022];
    int glog [0:1023];
    logic [9:0] gen [0:1][0:30];
    logic [9:0] msg [0:K-1];
    logic [9:0] par [0:29];

    always #5 clk = ~clk;

    rs_enc_dual dut (
        .clk(clk),
        .rst(rst),
        .mode(mode),
        .sop(sop),
        .valid_in(valid_in),
        .data_in(data_in),
        .ready(ready),
        .valid_out(valid_out),
        .data_out(data_out),
        .sop_out(sop_out),
        .eop_out(eop_out),
        .err_abort(err_abort)
    );

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    function automatic logic [9:0] gm(input logic [9:0] a, input logic [9:0] b);
        if (a == 0 || b == 0) return '0;
        return gexp[(glog[a] + glog[b]) % 1023];
    endfunction

    task automatic build_field();
        logic [10:0] x;
        int n;
        x = 11'h001;
        for (int i = 0; i < 1023; i++) begin
            gexp[i] = x[9:0];
            glog[x[9:0]] = i;
            x = x << 1;
            if (x[10]) x = x ^ 11'h409;
        end
        for (int m = 0; m < 2; m++) begin
            n = (m == 1) ? 14 : 30;
            for (int j = 0; j <= 30; j++) gen[m][j] = (j == 0) ? 10'h001 : 10'h000;
            for (int k = 0; k < n; k++) begin
                for (int j = k + 1; j > 0; j--) gen[m][j] = gen[m][j-1] ^ gm(gen[m][j], gexp[k]);
                gen[m][0] = gm(gen[m][0], gexp[k]);
            end
        end
    endtask

    // Remainder of msg(x)*x^n mod g(x); par[0] is the highest-degree parity.
    task automatic encode(input int m);
        int n;
        logic [9:0] c;
        logic [9:0] w [0:K+29];
        n = (m == 1) ? 14 : 30;
        for (int j = 0; j < K + 30; j++) w[j] = '0;
        for (int j = 0; j < K; j++) w[K-1-j+n] = msg[j];
        for (int d = K + n - 1; d >= n; d--) begin
            c = w[d];
            for (int i = 0; i <= n; i++) w[d-n+i] = w[d-n+i] ^ gm(c, gen[m][i]);
        end
        for (int j = 0; j < n; j++) par[j] = w[n-1-j];
    endtask

    task automatic send_sym(input logic [9:0] d, input logic s, input logic m);
        bit a;
        int t;
        t = 0;
        valid_in = 1'b1;
        sop = s;
        data_in = d;
        mode = m;
        do begin
            a = ready;
            @(posedge clk);
            #1;
            t++;
        end while (!a && t < 100);
        if (!a) begin
            checks++;
            errors++;
            $display("FAIL accept timeout: ready=0 for 100 cycles, expected 1");
        end
    endtask

    task automatic send_cw(input logic m, input bit gaps, input int npush, input bit want_err);
        int n;
        n = m ? 14 : 30;
        encode(int'(m));
        for (int j = 0; j < K; j++) sb.push_back('{d: msg[j], s: (j == 0), e: 1'b0});
        for (int j = 0; j < npush; j++) sb.push_back('{d: par[j], s: 1'b0, e: (j == n - 1)});
        for (int j = 0; j < K; j++) begin
            if (gaps) begin
                valid_in = 1'b0;
                repeat ($urandom_range(0, 2)) begin
                    @(posedge clk);
                    #1;
                end
            end
            send_sym(msg[j], j == 0, m);
            if (j == 0) chk("err_abort after sop", int'(err_abort), int'(want_err));
        end
        valid_in = 1'b0;
        sop = 1'b0;
    endtask

    task automatic fill(input int kind);
        for (int j = 0; j < K; j++)
            msg[j] = (kind == 2) ? 10'($urandom_range(0, 1023)) : (kind == 1 && j == K - 1) ? 10'h001 : 10'h000;
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (sb.size() != 0 && t < 2000) begin
            @(posedge clk);
            #1;
            t++;
        end
        chk("scoreboard drained", sb.size(), 0);
        repeat (3) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic count_low(input string name, input int req);
        int low;
        low = 0;
        while (!ready && low < 100) begin
            low++;
            @(posedge clk);
            #1;
        end
        chk(name, low, req);
    endtask

    always @(negedge clk) begin
        if (err_abort) err_pulses++;
        if (b2b_left > 0 && eop_seen) begin
            chk("sop right after eop", int'({valid_out, sop_out}), 3);
            b2b_left--;
        end
        eop_seen = valid_out && eop_out;
        if (valid_out) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected output: data_out=%0h, expected no output", data_out);
            end else begin
                cur = sb.pop_front();
                chk("data_out", int'(data_out), int'(cur.d));
                chk("sop_out", int'(sop_out), int'(cur.s));
                chk("eop_out", int'(eop_out), int'(cur.e));
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        build_field();
        repeat (2) @(posedge clk);
        #1;
        chk("reset ready", int'(ready), 0);
        chk("reset valid_out", int'(valid_out), 0);
        chk("reset data_out", int'(data_out), 0);
        chk("reset sop_out", int'(sop_out), 0);
        chk("reset eop_out", int'(eop_out), 0);
        chk("reset err_abort", int'(err_abort), 0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("ready after reset", int'(ready), 1);

        fill(0);
        send_cw(1'b0, 1'b0, 30, 1'b0);
        count_low("kp4 ready low cycles", 30);
        fill(1);
        send_cw(1'b0, 1'b0, 30, 1'b0);
        count_low("kp4 impulse ready low", 30);
        send_cw(1'b1, 1'b0, 14, 1'b0);
        count_low("kr4 impulse ready low", 14);

        fill(2);
        send_cw(1'b0, 1'b0, 30, 1'b0);
        send_cw(1'b0, 1'b1, 30, 1'b0);
        fill(2);
        send_cw(1'b1, 1'b1, 14, 1'b0);
        drain();

        b2b_left = 3;
        for (int c = 0; c < 4; c++) begin
            fill(2);
            send_cw(c[0], 1'b0, c[0] ? 14 : 30, 1'b0);
        end
        drain();
        chk("back-to-back transitions", b2b_left, 0);

        fill(2);
        for (int j = 0; j < 200; j++) sb.push_back('{d: msg[j], s: (j == 0), e: 1'b0});
        for (int j = 0; j < 200; j++) send_sym(msg[j], j == 0, 1'b0);
        fill(2);
        send_cw(1'b1, 1'b0, 14, 1'b1);
        drain();

        send_sym(10'h155, 1'b0, 1'b0);
        valid_in = 1'b0;
        chk("lone symbol err_abort", int'(err_abort), 1);
        @(posedge clk);
        #1;
        chk("err_abort one cycle", int'(err_abort), 0);

        fill(2);
        send_cw(1'b0, 1'b0, 10, 1'b0);
        repeat (10) begin
            @(posedge clk);
            #1;
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("mid-parity rst ready", int'(ready), 0);
        chk("mid-parity rst valid_out", int'(valid_out), 0);
        chk("mid-parity rst data_out", int'(data_out), 0);
        chk("mid-parity rst eop_out", int'(eop_out), 0);
        chk("mid-parity rst err_abort", int'(err_abort), 0);
        chk("mid-parity rst pending", sb.size(), 0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("ready after mid rst", int'(ready), 1);
        fill(2);
        send_cw(1'b1, 1'b0, 14, 1'b0);
        drain();

        chk("err_abort pulse count", err_pulses, 2);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/rs_enc_dual.md
# rs_enc_dual

Dual-mode systematic Reed-Solomon encoder over GF(2^10), one 10-bit symbol per cycle. It supports RS(544,514) "KP4" (30 parity symbols) and RS(528,514) "KR4" (14 parity symbols), with the mode selected per codeword at SOP. It sits in the FEC transmit path after the symbol mapper. It is the successor to the fixed KP4 encoder, and adds:
- runtime mode selection;
- input gaps (stalls);
- SOP/EOP framing on the output;
- abort detection.

## Interface
- `SYM_W`, 10: symbol width. Only 10 is supported, because the field is fixed.
- `K`, 514: message symbols per codeword, common to both modes.
- `NPAR_MAX`, 30: depth of the parity register file; must be ≥ 30.
- `clk` input 1: single clock, all logic on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `mode` input 1: 0 = KP4 (NPAR=30), 1 = KR4 (NPAR=14). Sampled only on an accepted SOP.
- `sop` input 1: marks the first message symbol; qualified by `valid_in`.
- `valid_in` input 1: input symbol valid.
- `data_in` input SYM_W: message symbol, highest-degree coefficient first.
- `ready` output 1: encoder accepts input this cycle.
- `valid_out` output 1: output symbol valid.
- `data_out` output SYM_W: codeword symbol (message, then parity).
- `sop_out` output 1: marks codeword symbol 0.
- `eop_out` output 1: marks the last parity symbol.
- `err_abort` output 1: one-cycle pulse on a framing error.

## Operation
- Field: primitive polynomial x^10+x^3+1, α = 0x002. Generator g(x) = ∏_{i=0}^{NPAR-1}(x − α^i), which is monic of degree NPAR.
- States:
  - IDLE: `ready` = 1; waiting for SOP.
  - DATA: `ready` = 1; accepting message symbols.
  - PARITY: `ready` = 0; draining parity.
- Accept condition: `valid_in && ready`.
- IDLE behaviour:
  - Accepted symbol with `sop` = 1: latch `mode` into `npar_q`, clear the parity registers, process the symbol, set count = 1, go to DATA.
  - Accepted symbol with `sop` = 0: dropped, `err_abort` pulses.
- DATA behaviour:
  - Each accepted symbol updates the LFSR: fb = d ^ r[npar_q−1]; r[i] = r[i−1] ^ fb·g_i; r[0] = fb·g_0.
  - Registers with index ≥ `npar_q` are held at 0.
  - `valid_in` = 0 stalls: no update, and no output that cycle.
  - The symbol that brings count to K is the last message symbol; go to PARITY.
  - Accepted `sop` mid-codeword aborts: `err_abort` pulses and the symbol is treated as a fresh SOP (mode re-sampled, LFSR restarted, count = 1). The aborted codeword emits no parity and no `eop_out`.
- PARITY behaviour:
  - Each cycle emits r[npar_q−1], shifts r[i] ← r[i−1], and clears r[0].
  - After `npar_q` cycles, return to IDLE.
  - `valid_in` is ignored while `ready` = 0.
- Output framing:
  - Every accepted message symbol is forwarded to `data_out` unchanged.
  - `sop_out` accompanies the forwarded SOP symbol.
  - `eop_out` accompanies parity index `npar_q`−1.
- Count arithmetic: a 10-bit unsigned message counter that cannot wrap (K < 1024). The parity counter is 5-bit.

## Timing
- Reset values: `ready` = 0 during the reset cycle; `valid_out` = `sop_out` = `eop_out` = `err_abort` = 0; `data_out` = 0; state = IDLE; all parity registers and counters = 0. `ready` = 1 on the first cycle after `rst` deasserts.
- `rst` mid-codeword or mid-parity: all of the above apply on the next edge, and the partial codeword is discarded silently (no `err_abort`).
- All outputs are registered, so `ready` comes from state only.
- Latency: message symbol accepted at cycle t appears on `data_out` at t+1.
- Last message symbol accepted at t:
  - State is PARITY from t+1.
  - Parity symbols appear on t+2 … t+NPAR+1, contiguous with the message when the input had no gaps.
  - `eop_out` is at t+NPAR+1.
  - `ready` = 0 on t+1 … t+NPAR; `ready` = 1 at t+NPAR+1.
- Throughput: an SOP may be accepted in the cycle `ready` returns to 1, giving zero idle cycles between codewords. Minimum period is K+NPAR cycles.
- `err_abort` rises one cycle after the offending accept.

## Structure
- Package `rs_pkg` holds:
  - GF constants (`GF_M` = 10, primitive polynomial 0x409);
  - a constant function `gf_mul`;
  - `typedef logic [9:0] sym_t`;
  - generator coefficient arrays `G_KP4[0:29]` and `G_KR4[0:13]`, precomputed as localparams;
  - `typedef enum {IDLE, DATA, PARITY} enc_state_t`;
  - mode encodings.
- Sub-module `gf1024_mul` (combinational symbol × symbol) is instantiated per tap. Its coefficient input is muxed between `G_KP4[i]` and `G_KR4[i]` by `npar_q`.

## Test plan
- KP4, all-zero 514-symbol message, no gaps → 544 zero symbols; `sop_out` on the first, `eop_out` on the 544th; `ready` low for exactly 30 cycles.
- KP4, message of all zeros except the final symbol = 0x001 → the 514 message symbols pass through unchanged, then parity equals G_KP4[29] … G_KP4[0]. Repeat in KR4 → 528 symbols, parity G_KR4[13] … G_KR4[0].
- Same random KP4 message sent twice (once contiguous, once with random `valid_in` gaps) → identical `data_out` sequences; compare against reference-model hex vectors for 100 random codewords per mode.
- Back-to-back codewords alternating KP4/KR4, each SOP on the cycle `ready` rises → correct parity for each codeword, no bubble between the last parity and the next SOP output.
- SOP asserted at message symbol 200 → `err_abort` pulse one cycle later; new codeword correct; no `eop_out` for the aborted one. Lone `valid_in` without `sop` in IDLE → dropped, `err_abort` pulses.
- `rst` asserted at parity symbol 10 → next cycle all outputs 0 and state IDLE; following codeword is encoded correctly.
